// File: rtl/logic_gate_pipe_if.sv
// Stream bundle for logic_gate_pipe: upstream beat channel (IN_*) and
// downstream result channel (OUT_*). The slave modport is the block's view;
// the master modport is the producer/consumer view that drives it.
interface logic_gate_pipe_if #(
    parameter int WIDTH  = 8,
    parameter int NUM_IN = 2,
    parameter int CNT_W  = 8
);
    logic [NUM_IN*WIDTH-1:0] IN_data;
    logic [2:0]              IN_op;
    logic                    IN_acc;
    logic                    IN_last;
    logic                    IN_valid;
    logic                    IN_ready;
    logic [WIDTH-1:0]        OUT_x;
    logic [CNT_W-1:0]        OUT_count;
    logic                    OUT_allone;
    logic                    OUT_err;
    logic                    OUT_valid;
    logic                    OUT_ready;

    modport master (
        output IN_data, IN_op, IN_acc, IN_last, IN_valid, OUT_ready,
        input  IN_ready, OUT_x, OUT_count, OUT_allone, OUT_err, OUT_valid
    );

    modport slave (
        input  IN_data, IN_op, IN_acc, IN_last, IN_valid, OUT_ready,
        output IN_ready, OUT_x, OUT_count, OUT_allone, OUT_err, OUT_valid
    );
endinterface

// File: rtl/logic_gate_pipe.sv
// Streaming bitwise reducer: folds NUM_IN operands per beat with a selectable
// AND/OR/XOR base op (optionally inverted), optionally accumulating over a
// multi-beat packet, with one registered output stage.
//
// Handshake: a beat moves when IN_valid && IN_ready; a result moves when
// OUT_valid && OUT_ready. IN_ready = !OUT_valid || OUT_ready, so a result can
// be replaced in the same edge it is taken, and OUT_* hold while stalled.
module logic_gate_pipe #(
    parameter int WIDTH  = 8,
    parameter int NUM_IN = 2,
    parameter int CNT_W  = 8
) (
    input  logic                 CLK,
    input  logic                 RST_n,
    logic_gate_pipe_if.slave     bus,
    output logic                 dbg_state
);
    typedef enum logic {IDLE = 1'b0, ACCUM = 1'b1} state_t;

    localparam logic [1:0] BASE_AND = 2'd0;
    localparam logic [1:0] BASE_OR  = 2'd1;
    localparam logic [1:0] BASE_XOR = 2'd2;
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    function automatic logic [1:0] base_of(input logic [2:0] op);
        case (op)
            3'd1, 3'd4: base_of = BASE_OR;
            3'd2, 3'd5: base_of = BASE_XOR;
            default:    base_of = BASE_AND;  // 0, 3 and reserved 6/7
        endcase
    endfunction

    function automatic logic inverts(input logic [2:0] op);
        inverts = (op == 3'd3) || (op == 3'd4) || (op == 3'd5);
    endfunction

    function automatic logic reserved(input logic [2:0] op);
        reserved = op[2] & op[1];
    endfunction

    function automatic logic [WIDTH-1:0] combine(input logic [WIDTH-1:0] a,
                                                 input logic [WIDTH-1:0] b,
                                                 input logic [1:0]       base);
        case (base)
            BASE_OR:  combine = a | b;
            BASE_XOR: combine = a ^ b;
            default:  combine = a & b;
        endcase
    endfunction

    state_t           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       op_q, op_d;
    logic             err_q, err_d;

    logic [WIDTH-1:0] out_x_q;
    logic [CNT_W-1:0] out_count_q;
    logic             out_allone_q, out_err_q, out_valid_q;

    logic             accept, emit;
    logic [2:0]       eff_op;
    logic [1:0]       base;
    logic [WIDTH-1:0] r, folded, result;
    logic [CNT_W-1:0] cnt_inc, out_count_d;
    logic             out_err_d;

    assign bus.IN_ready   = !out_valid_q || bus.OUT_ready;
    assign accept         = bus.IN_valid && bus.IN_ready;
    assign bus.OUT_x      = out_x_q;
    assign bus.OUT_count  = out_count_q;
    assign bus.OUT_allone = out_allone_q;
    assign bus.OUT_err    = out_err_q;
    assign bus.OUT_valid  = out_valid_q;
    assign dbg_state      = state_q;

    // Datapath: beat reduction under the governing op, fold into accumulator, final inversion.
    always_comb begin
        eff_op = (state_q == ACCUM) ? op_q : bus.IN_op;
        base   = base_of(eff_op);
        r      = bus.IN_data[WIDTH-1:0];
        for (int k = 1; k < NUM_IN; k++) begin
            r = combine(r, bus.IN_data[k*WIDTH +: WIDTH], base);
        end
        folded  = (state_q == ACCUM) ? combine(acc_q, r, base) : r;
        result  = inverts(eff_op) ? ~folded : folded;
        cnt_inc = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + 1'b1;
    end

    // Next-state: packet tracking and decision to emit a result this edge.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        op_d        = op_q;
        err_d       = err_q;
        emit        = 1'b0;
        out_count_d = CNT_ONE;
        out_err_d   = reserved(bus.IN_op);
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (bus.IN_acc && !bus.IN_last) begin
                        state_d = ACCUM;
                        op_d    = bus.IN_op;
                        acc_d   = r;
                        cnt_d   = CNT_ONE;
                        err_d   = reserved(bus.IN_op);
                    end else begin
                        emit = 1'b1;
                    end
                end
            end
            ACCUM: begin
                if (accept) begin
                    if (bus.IN_last) begin
                        emit        = 1'b1;
                        state_d     = IDLE;
                        out_count_d = cnt_inc;
                        out_err_d   = err_q;
                    end else begin
                        acc_d = folded;
                        cnt_d = cnt_inc;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Packet state registers; reset drops any partial packet.
    always_ff @(posedge CLK) begin
        if (!RST_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            op_q    <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            err_q   <= err_d;
        end
    end

    // Output stage: load on emit, drop valid after transfer, otherwise hold.
    always_ff @(posedge CLK) begin
        if (!RST_n) begin
            out_x_q      <= '0;
            out_count_q  <= '0;
            out_allone_q <= 1'b0;
            out_err_q    <= 1'b0;
            out_valid_q  <= 1'b0;
        end else if (emit) begin
            out_x_q      <= result;
            out_count_q  <= out_count_d;
            out_allone_q <= &result;
            out_err_q    <= out_err_d;
            out_valid_q  <= 1'b1;
        end else if (bus.OUT_ready) begin
            out_valid_q  <= 1'b0;
        end
    end
endmodule
